video_mode_ctrl: RTL and testbench
==================================

// Module: video_mode_ctrl
// PURPOSE
//  Run-time configuration controller for the pixel-processing pipeline (colour/greyscale/threshold).
//  Debounces the four board buttons and turns presses into a pending mode/threshold request.
//  Commits the request only at a frame boundary (vsync rising edge), so the datapath never changes mid-frame.
//  Drives the mode select and threshold of the greyscale datapath, and counts frames.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  clk cycles a synchronised button level must stay stable before it is accepted
//  THRESH_DEFAULT   8'd128   threshold value after reset and after btn[3]
//  THRESH_STEP      8'd8     threshold increment/decrement per press
// PORTS
//  clk            in   1   pixel clock; the block's only clock
//  n_rst          in   1   reset, asynchronous assert, active-low
//  btn            in   4   raw buttons: [0] next mode, [1] thresh up, [2] thresh down, [3] restore defaults
//  i_vid_vsync    in   1   vsync from the video timing; active-high
//  o_mode         out  2   active mode: 0 PASS, 1 GREY, 2 THRESH (3 never driven)
//  o_threshold    out  8   active threshold
//  o_cfg_update   out  1   one-cycle pulse in the cycle after new o_mode/o_threshold are committed
//  o_pending      out  1   high while an uncommitted request exists (state PENDING)
//  o_frame_cnt    out  16  count of vsync rising edges since reset
// BEHAVIOUR
//  Reset (n_rst=0, async): o_mode=PASS, o_threshold=THRESH_DEFAULT, o_cfg_update=0, o_pending=0, o_frame_cnt=0.
//   Shadow regs are set equal to the active values. Sync/debounce regs are set to 0. vsync_q=0. The FSM goes to IDLE.
//   Reset mid-PENDING discards the request.
//  Button path, per bit:
//   - 2-flop synchroniser, then a debounce counter.
//   - The counter clears when the synced level differs from the debounced level.
//   - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level.
//   - press[i] = one-cycle pulse on the debounced rising edge. Releases do nothing.
//  Shadow update happens on the edge of the cycle where any press[i]=1. Priority, per cycle:
//   - press[3]: shadow_mode=PASS, shadow_thresh=THRESH_DEFAULT. All other presses that cycle are ignored.
//   - press[0]: shadow_mode PASS->GREY->THRESH->PASS.
//   - press[1] and press[2] together: they cancel; shadow_thresh is unchanged.
//   - press[1] alone: shadow_thresh = min(255, shadow_thresh+THRESH_STEP). Compute in 9 bits, then saturate.
//   - press[2] alone: shadow_thresh = max(0, shadow_thresh-THRESH_STEP). Compute in 9 bits, then saturate.
//   - press[0] combines with a threshold change in the same cycle.
//  vsync edge: vsync_q <= i_vid_vsync. vs_rise = i_vid_vsync & ~vsync_q (combinational).
//   - o_frame_cnt increments on every vs_rise and wraps 0xFFFF->0x0000.
//  FSM (2 states):
//   - IDLE -> PENDING on any press.
//   - PENDING & vs_rise: copy shadow to o_mode/o_threshold; o_cfg_update=1 next cycle.
//     Next state is PENDING if a press occurs in that same cycle (that press updates the shadow and waits
//     for the next frame), else IDLE.
//   - PENDING & ~vs_rise: stay. Further presses keep updating the shadow; only the last value is committed.
//   - IDLE & vs_rise: no commit, no pulse.
//  o_pending = (state==PENDING). It is registered.
//  Latency: press -> shadow in 1 cycle. vs_rise cycle -> outputs valid on the next cycle.
//   Debounce adds DEBOUNCE_CYCLES+2 cycles after a raw edge.
//  A commit where shadow equals active still pulses o_cfg_update.
// STRUCTURE
//  Package video_ctrl_pkg:
//   - MODE_PASS=2'd0, MODE_GREY=2'd1, MODE_THRESH=2'd2
//   - ST_IDLE/ST_PENDING encoding
//   - BTN_NEXT/BTN_UP/BTN_DOWN/BTN_DEFAULT bit indices
//  Sub-module btn_debounce:
//   - params DEBOUNCE_CYCLES; ports clk, n_rst, i_btn, o_level, o_press
//   - instantiated 4x via generate
//   - counter width $clog2(DEBOUNCE_CYCLES+1)
//  Top holds the shadow regs, the FSM, vsync edge detect and the frame counter.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset: n_rst low mid-cycle, async.
//     -> o_mode=0, o_threshold=128, o_pending=0, o_frame_cnt=0 immediately, without waiting for a clk edge.
//  2. btn[0] high 3 cycles (glitch) -> no press, o_pending stays 0.
//     btn[0] held 10 cycles -> o_pending=1, o_mode still 0.
//     Then vsync 0->1 -> o_mode=1 and o_cfg_update=1 for exactly one cycle.
//  3. 20 btn[1] presses (mode THRESH) plus one vsync -> o_threshold=255 (saturated).
//     Then 40 btn[2] presses plus vsync -> o_threshold=0.
//  4. btn[1] and btn[2] pressed in the same debounced cycle -> shadow unchanged; after vsync o_threshold=128.
//     o_cfg_update still pulses.
//  5. A press lands in the vs_rise cycle while PENDING -> the earlier value commits, o_pending stays 1,
//     the new value commits on the next vsync.
//  6. btn[3] plus btn[0] in the same cycle -> defaults win: o_mode=0, o_threshold=128 after vsync.
//     65536 vsync pulses -> o_frame_cnt=0.

Source files
------------

// File: rtl/video_ctrl_pkg.sv
// Shared encodings for the video mode controller: modes, FSM states, button indices.
package video_ctrl_pkg;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_GREY   = 2'd1;
    localparam logic [1:0] MODE_THRESH = 2'd2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam int BTN_NEXT    = 0;
    localparam int BTN_UP      = 1;
    localparam int BTN_DOWN    = 2;
    localparam int BTN_DEFAULT = 3;

    // Mode cycle PASS -> GREY -> THRESH -> PASS; the unused code 3 falls back to PASS.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        case (mode)
            MODE_PASS: next_mode = MODE_GREY;
            MODE_GREY: next_mode = MODE_THRESH;
            default:   next_mode = MODE_PASS;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser and debouncer; emits a one-cycle pulse on an accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Synchronise, then accept the new level once it has differed from the debounced level long enough.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/video_mode_ctrl.sv
// Button-driven mode/threshold configuration, committed to the datapath only at vsync rising edges.
module video_mode_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [7:0] THRESH_DEFAULT  = 8'd128,
    parameter logic [7:0] THRESH_STEP     = 8'd8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [3:0]  btn,
    input  logic        i_vid_vsync,
    output logic [1:0]  o_mode,
    output logic [7:0]  o_threshold,
    output logic        o_cfg_update,
    output logic        o_pending,
    output logic [15:0] o_frame_cnt
);

    logic [3:0] w_level;
    logic [3:0] w_press_raw;
    logic [3:0] w_press;
    logic       w_any_press;
    logic       w_vs_rise;
    logic [8:0] w_up_sum;
    logic [8:0] w_dn_diff;
    logic [1:0] w_shadow_mode_nx;
    logic [7:0] w_shadow_thresh_nx;

    logic [1:0] r_shadow_mode;
    logic [7:0] r_shadow_thresh;
    logic       r_vsync_q;
    state_t     r_state;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
            .clk     (clk),
            .n_rst   (n_rst),
            .i_btn   (btn[g]),
            .o_level (w_level[g]),
            .o_press (w_press_raw[g])
        );
    end

    // A press pulse always coincides with the debounced level being high.
    assign w_press     = w_press_raw & w_level;
    assign w_any_press = |w_press;
    assign w_vs_rise   = i_vid_vsync & ~r_vsync_q;
    assign w_up_sum    = {1'b0, r_shadow_thresh} + {1'b0, THRESH_STEP};
    assign w_dn_diff   = {1'b0, r_shadow_thresh} - {1'b0, THRESH_STEP};

    // Next shadow value: restore-defaults overrides everything; up+down together cancel.
    always_comb begin
        w_shadow_mode_nx   = r_shadow_mode;
        w_shadow_thresh_nx = r_shadow_thresh;
        if (w_press[BTN_DEFAULT]) begin
            w_shadow_mode_nx   = MODE_PASS;
            w_shadow_thresh_nx = THRESH_DEFAULT;
        end else begin
            if (w_press[BTN_NEXT]) begin
                w_shadow_mode_nx = next_mode(r_shadow_mode);
            end
            if (w_press[BTN_UP] && !w_press[BTN_DOWN]) begin
                w_shadow_thresh_nx = w_up_sum[8] ? 8'hFF : w_up_sum[7:0];
            end else if (w_press[BTN_DOWN] && !w_press[BTN_UP]) begin
                w_shadow_thresh_nx = w_dn_diff[8] ? 8'h00 : w_dn_diff[7:0];
            end
        end
    end

    // Shadow registers follow every accepted press.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shadow_mode   <= MODE_PASS;
            r_shadow_thresh <= THRESH_DEFAULT;
        end else if (w_any_press) begin
            r_shadow_mode   <= w_shadow_mode_nx;
            r_shadow_thresh <= w_shadow_thresh_nx;
        end
    end

    // Vsync edge detect and free-running frame counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_vsync_q   <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            r_vsync_q <= i_vid_vsync;
            if (w_vs_rise) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

    // Commit FSM: holds a request until the next frame boundary, registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            o_mode       <= MODE_PASS;
            o_threshold  <= THRESH_DEFAULT;
            o_cfg_update <= 1'b0;
            o_pending    <= 1'b0;
        end else begin
            o_cfg_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_press) begin
                        r_state   <= ST_PENDING;
                        o_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (w_vs_rise) begin
                        // Commit the shadow as it stood before any press in this same cycle.
                        o_mode       <= r_shadow_mode;
                        o_threshold  <= r_shadow_thresh;
                        o_cfg_update <= 1'b1;
                        r_state      <= w_any_press ? ST_PENDING : ST_IDLE;
                        o_pending    <= w_any_press;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    o_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed self-checking bench for video_mode_ctrl with a short debounce window.
module tb_video_mode_ctrl;

    logic        clk;
    logic        n_rst;
    logic [3:0]  btn;
    logic        i_vid_vsync;
    logic [1:0]  o_mode;
    logic [7:0]  o_threshold;
    logic        o_cfg_update;
    logic        o_pending;
    logic [15:0] o_frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    video_mode_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .THRESH_DEFAULT  (8'd128),
        .THRESH_STEP     (8'd8)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .btn          (btn),
        .i_vid_vsync  (i_vid_vsync),
        .o_mode       (o_mode),
        .o_threshold  (o_threshold),
        .o_cfg_update (o_cfg_update),
        .o_pending    (o_pending),
        .o_frame_cnt  (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold a button pattern well past the debounce window, then release it.
    task automatic press(input logic [3:0] b);
        @(negedge clk) btn = b;
        repeat (10) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    // One vsync pulse with checks of the commit result and pulse width.
    task automatic vsync_commit(input string tag, input logic [1:0] mode, input logic [7:0] thr,
                                input logic pulse);
        @(negedge clk) i_vid_vsync = 1'b1;
        @(negedge clk);
        check({tag, "_cfg_update"}, {31'd0, o_cfg_update}, {31'd0, pulse});
        check({tag, "_mode"}, {30'd0, o_mode}, {30'd0, mode});
        check({tag, "_threshold"}, {24'd0, o_threshold}, {24'd0, thr});
        i_vid_vsync = 1'b0;
        exp_frames++;
        @(negedge clk);
        check({tag, "_cfg_update_off"}, {31'd0, o_cfg_update}, 32'd0);
        check({tag, "_frame_cnt"}, {16'd0, o_frame_cnt}, exp_frames);
    endtask

    initial begin
        n_rst       = 1'b1;
        btn         = 4'b0000;
        i_vid_vsync = 1'b0;

        // 1. Asynchronous reset mid-cycle
        #23 n_rst = 1'b0;
        #1;
        check("rst_mode", {30'd0, o_mode}, 32'd0);
        check("rst_threshold", {24'd0, o_threshold}, 32'd128);
        check("rst_pending", {31'd0, o_pending}, 32'd0);
        check("rst_frame_cnt", {16'd0, o_frame_cnt}, 32'd0);
        check("rst_cfg_update", {31'd0, o_cfg_update}, 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // IDLE vsync: no commit pulse
        vsync_commit("idle_vs", 2'd0, 8'd128, 1'b0);

        // 2. Glitch rejected, then a real press of next-mode
        @(negedge clk) btn = 4'b0001;
        repeat (3) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        check("glitch_pending", {31'd0, o_pending}, 32'd0);
        press(4'b0001);
        check("next_pending", {31'd0, o_pending}, 32'd1);
        check("next_mode_held", {30'd0, o_mode}, 32'd0);
        vsync_commit("next_commit", 2'd1, 8'd128, 1'b1);
        check("next_pending_clr", {31'd0, o_pending}, 32'd0);

        // 3. Threshold saturation both ways in THRESH mode
        press(4'b0001);
        for (int i = 0; i < 20; i++) press(4'b0010);
        vsync_commit("sat_hi", 2'd2, 8'd255, 1'b1);
        for (int i = 0; i < 40; i++) press(4'b0100);
        vsync_commit("sat_lo", 2'd2, 8'd0, 1'b1);

        // 4. Restore defaults, then up+down together cancel
        press(4'b1000);
        vsync_commit("restore", 2'd0, 8'd128, 1'b1);
        press(4'b0110);
        check("cancel_pending", {31'd0, o_pending}, 32'd1);
        vsync_commit("cancel", 2'd0, 8'd128, 1'b1);

        // 5. Press coinciding with the vs_rise cycle while PENDING
        press(4'b0010);
        @(negedge clk) btn = 4'b0010;
        repeat (6) @(posedge clk);
        @(negedge clk) i_vid_vsync = 1'b1;
        @(negedge clk);
        check("race_cfg_update", {31'd0, o_cfg_update}, 32'd1);
        check("race_threshold", {24'd0, o_threshold}, 32'd136);
        check("race_pending", {31'd0, o_pending}, 32'd1);
        i_vid_vsync = 1'b0;
        exp_frames++;
        repeat (8) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        check("race_pending_hold", {31'd0, o_pending}, 32'd1);
        vsync_commit("race_second", 2'd0, 8'd144, 1'b1);

        // 6. Defaults beat next-mode in the same cycle
        press(4'b0001);
        press(4'b1001);
        vsync_commit("default_wins", 2'd0, 8'd128, 1'b1);

        // Frame counter wrap from reset
        @(negedge clk) n_rst = 1'b0;
        @(negedge clk);
        check("rst2_frame_cnt", {16'd0, o_frame_cnt}, 32'd0);
        n_rst = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk) i_vid_vsync = 1'b1;
            @(negedge clk) i_vid_vsync = 1'b0;
        end
        @(negedge clk);
        check("frame_cnt_max", {16'd0, o_frame_cnt}, 32'h0000FFFF);
        i_vid_vsync = 1'b1;
        @(negedge clk) i_vid_vsync = 1'b0;
        @(negedge clk);
        check("frame_cnt_wrap", {16'd0, o_frame_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
